// File: rtl/rx_fifo_if.sv
// Bus between the UART receiver side, the FIFO and its consumer.
// The master modport is the side that feeds bytes in and pulls them out.
interface rx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] rx_data;
   logic              rx_done;
   logic              rd_en;
   logic              clr_ovf;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [CW-1:0]     count;
   logic              overflow;

   modport master (
      output rx_data, rx_done, rd_en, clr_ovf,
      input  rd_data, rd_valid, empty, full, count, overflow
   );

   modport slave (
      input  rx_data, rx_done, rd_en, clr_ovf,
      output rd_data, rd_valid, empty, full, count, overflow
   );
endinterface

// File: rtl/rx_fifo.sv
// Receive FIFO behind a UART receiver: one write per rx_done rising edge,
// registered reads, a count-based empty/full, and a sticky overflow flag.
module rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input logic      clk,
   input logic      rst,
   rx_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic              rx_done_q;
   logic              rd_valid_q;
   logic              overflow_q;
   logic [DATA_W-1:0] rd_data_q;

   logic empty_c;
   logic full_c;
   logic wr_evt;
   logic rd_acc;
   logic wr_acc;
   logic drop;

   // A read in the same cycle frees a slot, so a full FIFO can still take the write.
   always_comb begin
      empty_c = (count_q == '0);
      full_c  = (count_q == CW'(DEPTH));
      wr_evt  = bus.rx_done & ~rx_done_q;
      rd_acc  = bus.rd_en & ~empty_c;
      wr_acc  = wr_evt & (~full_c | rd_acc);
      drop    = wr_evt & full_c & ~rd_acc;
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr] <= bus.rx_data;
      end
   end

   // rx_done_q resets high so a level held through reset is not seen as a new byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_done_q  <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         rx_done_q  <= bus.rx_done;
         rd_valid_q <= rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr    <= rd_ptr + AW'(1);
            rd_data_q <= mem[rd_ptr];
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (bus.clr_ovf) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty_c;
   assign bus.full     = full_c;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: byte width, matching the receiver's rx_data.
REQ-002 SHALL have parameter DEPTH, default 16: entry count; must be a power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: single system clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_data, input, DATA_W: received byte from the UART receiver.
REQ-006 SHALL have port rx_done, input, 1: receiver completion flag; may stay high for many cycles.
REQ-007 SHALL have port rd_en, input, 1: consumer read request.
REQ-008 SHALL have port clr_ovf, input, 1: clears the sticky overflow flag.
REQ-009 SHALL have port rd_data, output, DATA_W: registered read data.
REQ-010 SHALL have port rd_valid, output, 1: one-cycle pulse; rd_data is valid in this cycle.
REQ-011 SHALL have port empty, output, 1: high when count == 0.
REQ-012 SHALL have port full, output, 1: high when count == DEPTH.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: number of stored entries.
REQ-014 SHALL have port overflow, output, 1: sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-015 SHALL register rx_done into rx_done_q; a write event SHALL be rx_done & ~rx_done_q, giving exactly one write per rx_done high period, however long that period is.
REQ-016 SHALL, on a write event with full low, store rx_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-017 SHALL accept a read when rd_en & ~empty: rd_data <= mem[rd_ptr], rd_ptr increments modulo DEPTH, rd_valid = 1 on the next cycle.
REQ-018 SHALL ignore rd_en while empty: no pointer change, rd_valid stays 0, rd_data holds its last value.
REQ-019 SHALL update count on the same edge as pointer changes: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 SHALL, on a simultaneous write event and read while full, accept both; count stays DEPTH and overflow is not set.
REQ-021 SHALL, on a simultaneous write event and rd_en while empty, accept the write and ignore the read; count becomes 1.
REQ-022 SHALL, on a write event while full with no accepted read, drop the byte, leave the pointers and count unchanged, and set overflow.
REQ-023 SHALL clear overflow on clr_ovf; if clr_ovf and a new drop occur in the same cycle, overflow SHALL remain 1.
REQ-024 SHALL derive empty and full combinationally from count; pointer wrap-around SHALL NOT affect correctness.
REQ-025 SHALL preserve byte order: bytes are read out in the order their write events occurred.

Reset
REQ-026 SHALL, with rst high, set wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0, rd_valid = 0, rd_data = 0.
REQ-027 SHALL set rx_done_q = 1 during reset, so an rx_done level held high through reset is not captured.
REQ-028 SHALL give rst priority over all other inputs; reset mid-operation discards all stored bytes.
REQ-029 SHALL NOT require the memory array contents to be reset.
REQ-030 SHALL give empty = 1, full = 0, count = 0 on the first cycle after rst falls.

Verification
REQ-031 Reset, then pulse rx_done with rx_data 0xA5 -> count = 1, empty = 0; then rd_en for one cycle -> next cycle rd_valid = 1, rd_data = 0xA5, empty = 1.
REQ-032 Hold rx_done high for 5000 cycles with rx_data 0x3C -> exactly one entry stored, count = 1.
REQ-033 Write 0x00..0x0F (16 write events), then a 17th write of 0xFF -> full = 1, count = 16, overflow = 1; 16 reads return 0x00..0x0F in order; clr_ovf -> overflow = 0.
REQ-034 When full, write event plus rd_en in the same cycle -> count stays 16, overflow = 0, oldest byte read out, new byte stored last.
REQ-035 When empty, rd_en alone -> rd_valid = 0, count = 0; write event plus rd_en together -> count = 1, rd_valid = 0.
REQ-036 With 3 entries stored, assert rst for one cycle while rx_done is high -> count = 0, empty = 1, overflow = 0, and no capture after rst falls until rx_done goes low and rises again.
